alu_shift_pipe: RTL and testbench
=================================

Name: alu_shift_pipe

Overview:
- Parametrised, pipelined shift/rotate unit for the ALU; next generation of the single-cycle 32-bit shifter.
- Adds configurable width, selectable op mode (logical left/right, arithmetic right, rotate left/right) and configurable pipeline depth.
- Adds a valid/ready handshake at both ends with full backpressure.
- Sits between operand select and ALU result mux; issue logic drives the input side, writeback drives the output side.

Parameters:
- WIDTH, 32, data width in bits; power of two, 8..64.
- SHAMT_W, $clog2(WIDTH), shift-amount field width; derived, do not override.
- PIPE_STAGES, 2, pipeline register stages, 1..SHAMT_W; equals latency in cycles.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input operation valid.
- in_ready  out  1  unit accepts input this cycle.
- in_op  in  3  0=SLL 1=SRL 2=SRA 3=ROL 4=ROR; 5..7 illegal.
- in_data  in  WIDTH  operand to shift.
- in_shamt  in  WIDTH  shift amount; only low SHAMT_W bits used.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  shifted/rotated result.
- out_illegal  out  1  op was 5..7; out_data = in_data unchanged.

Behaviour:
- Reset (async assert, sync-safe release): all stage valid bits 0; out_valid=0, out_data=0, out_illegal=0; in_ready=1 after reset.
- Transfer occurs when valid&&ready is high on a rising clk edge, at both input and output.
- Amount: sh = in_shamt[SHAMT_W-1:0]; upper bits are ignored, so shamt=WIDTH behaves as 0.
- Decomposition: logarithmic barrel. Bit i of sh is applied in stage floor(i*PIPE_STAGES/SHAMT_W). Op, sign and partial result travel with each stage.
- SRA fill: uses original in_data[WIDTH-1] at every stage, not the partial result MSB.
- Latency: accepted op appears with out_valid=1 exactly PIPE_STAGES cycles later when there are no stalls.
- Throughput: 1 op/cycle.
- Stall: the pipeline is a single global-enable chain.
  - advance = !out_valid || out_ready; in_ready = advance.
  - On !advance every stage holds, and out_data/out_illegal stay stable while out_valid=1.
  - Bubbles are not compressed.
- Simultaneous accept and drain in the same cycle is legal and required; no lost or duplicated ops.
- out_valid drops the cycle after a drain if no valid op is in the stage behind it.
- Reset mid-operation: all in-flight ops are discarded; no partial result is emitted.
- Illegal op: passes through with identical latency; out_illegal=1, out_data=in_data.
- No combinational path from in_* to out_*. in_ready depends combinationally only on out_valid and out_ready.

Optional Feature:
- Macro: ALU_SHIFT_CARRY_EN.
- Defined: adds port out_carry (out, 1), pipelined and stalled alongside out_data, reset value 0.
  - SLL: carry = in_data[WIDTH-sh].
  - SRL/SRA: carry = in_data[sh-1].
  - sh=0, rotates, illegal: carry = 0.
- Undefined: port absent; no carry logic or registers.

Test Plan:
- Reset release, WIDTH=32, PIPE_STAGES=2: SLL 0x0000_0001 by 31 -> 2 cycles later out_data=0x8000_0000, out_valid=1 for 1 cycle (out_ready=1).
- SRA 0x8000_00F0 by 4 -> 0xF800_000F; SRL same operand -> 0x0800_000F; with carry macro both give out_carry=0.
- ROR 0x1234_5678 by 8 -> 0x7812_3456; ROL by shamt 0x28 (masked to 8) -> 0x3456_7812.
- Back-to-back 4 ops with out_ready low for 3 cycles from cycle 3 -> in_ready=0 while stalled, out_data held stable, all 4 results in order with no loss.
- in_op=6, data 0xDEAD_BEEF -> out_illegal=1, out_data=0xDEAD_BEEF at normal latency; assert rst_n=0 with 2 ops in flight -> out_valid=0 immediately, no result after release.
- WIDTH=8, PIPE_STAGES=1 build: SLL 0x81 by 1 -> out_data=0x02 next cycle, out_carry=1 with ALU_SHIFT_CARRY_EN.

Source files
------------

// File: rtl/alu_shift_pipe_if.sv
// Handshake bundle for the pipelined shift/rotate unit.
// master: issue/writeback side; slave: the shift unit itself.
// With ALU_SHIFT_CARRY_EN defined the bundle also carries out_carry.
interface alu_shift_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] in_shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_illegal;
`ifdef ALU_SHIFT_CARRY_EN
    logic             out_carry;
`endif

    modport master (
        output in_valid, in_op, in_data, in_shamt, out_ready,
        input  in_ready, out_valid, out_data,
`ifdef ALU_SHIFT_CARRY_EN
               out_carry,
`endif
               out_illegal
    );

    modport slave (
        input  in_valid, in_op, in_data, in_shamt, out_ready,
        output in_ready, out_valid, out_data,
`ifdef ALU_SHIFT_CARRY_EN
               out_carry,
`endif
               out_illegal
    );
endinterface

// File: rtl/alu_shift_pipe.sv
// Pipelined logarithmic barrel shifter/rotator with valid/ready at both ends.
// Shift-amount bit i is applied in stage floor(i*PIPE_STAGES/SHAMT_W); all stages
// share one enable, so a stalled output freezes the whole pipe.
// Optional: define ALU_SHIFT_CARRY_EN to add the out_carry result bit.
module alu_shift_pipe #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned PIPE_STAGES = 2
) (
    input logic             clk,
    input logic             rst_n,
    alu_shift_pipe_if.slave bus
);
    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    localparam logic [2:0] OpSll = 3'd0;
    localparam logic [2:0] OpSrl = 3'd1;
    localparam logic [2:0] OpSra = 3'd2;
    localparam logic [2:0] OpRol = 3'd3;
    localparam logic [2:0] OpRor = 3'd4;

    // Register k holds the result of stage k.
    logic [WIDTH-1:0]       data_q [PIPE_STAGES];
    logic [2:0]             op_q   [PIPE_STAGES];
    logic [SHAMT_W-1:0]     sh_q   [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] sign_q, illegal_q, valid_q;

    // Inputs to stage k and its combinational result.
    logic [WIDTH-1:0]       st_data [PIPE_STAGES];
    logic [2:0]             st_op   [PIPE_STAGES];
    logic [SHAMT_W-1:0]     st_sh   [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] st_sign, st_illegal, st_valid;
    logic [WIDTH-1:0]       data_d  [PIPE_STAGES];

    logic advance;

    function automatic logic [WIDTH-1:0] shift_step(input logic [2:0] op, input logic sign,
                                                    input logic [WIDTH-1:0] v,
                                                    input int unsigned amt);
        logic [WIDTH-1:0] r;
        case (op)
            OpSll:   r = v << amt;
            OpSrl:   r = v >> amt;
            // Fill from the original operand sign, never the partial result.
            OpSra:   r = sign ? ~((~v) >> amt) : (v >> amt);
            OpRol:   r = (v << amt) | (v >> (WIDTH - amt));
            OpRor:   r = (v >> amt) | (v << (WIDTH - amt));
            default: r = v;
        endcase
        return r;
    endfunction

    assign advance      = !valid_q[PIPE_STAGES-1] || bus.out_ready;
    assign bus.in_ready = advance;

    // Stage inputs: ports feed stage 0, each later stage reads the register ahead of it.
    always_comb begin
        st_data[0]    = bus.in_data;
        st_op[0]      = bus.in_op;
        st_sh[0]      = bus.in_shamt[SHAMT_W-1:0];
        st_sign[0]    = bus.in_data[WIDTH-1];
        st_illegal[0] = bus.in_op > OpRor;
        st_valid[0]   = bus.in_valid;
        for (int k = 1; k < PIPE_STAGES; k++) begin
            st_data[k]    = data_q[k-1];
            st_op[k]      = op_q[k-1];
            st_sh[k]      = sh_q[k-1];
            st_sign[k]    = sign_q[k-1];
            st_illegal[k] = illegal_q[k-1];
            st_valid[k]   = valid_q[k-1];
        end
    end

    // Each stage applies only the shift-amount bits assigned to it.
    always_comb begin
        for (int k = 0; k < PIPE_STAGES; k++) begin
            data_d[k] = st_data[k];
            for (int i = 0; i < SHAMT_W; i++) begin
                if (int'((i * PIPE_STAGES) / SHAMT_W) == k && st_sh[k][i] && !st_illegal[k]) begin
                    data_d[k] = shift_step(st_op[k], st_sign[k], data_d[k], 1 << i);
                end
            end
        end
    end

    // Global-enable pipeline registers; reset flushes everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < PIPE_STAGES; k++) begin
                data_q[k] <= '0;
                op_q[k]   <= '0;
                sh_q[k]   <= '0;
            end
            sign_q    <= '0;
            illegal_q <= '0;
            valid_q   <= '0;
        end else if (advance) begin
            for (int k = 0; k < PIPE_STAGES; k++) begin
                data_q[k] <= data_d[k];
                op_q[k]   <= st_op[k];
                sh_q[k]   <= st_sh[k];
            end
            sign_q    <= st_sign;
            illegal_q <= st_illegal;
            valid_q   <= st_valid;
        end
    end

    assign bus.out_valid   = valid_q[PIPE_STAGES-1];
    assign bus.out_data    = data_q[PIPE_STAGES-1];
    assign bus.out_illegal = illegal_q[PIPE_STAGES-1];

`ifdef ALU_SHIFT_CARRY_EN
    logic [PIPE_STAGES-1:0] carry_q;
    logic                   carry_in;
    logic [SHAMT_W-1:0]     sll_idx, srl_idx;

    // Carry is the last bit shifted out, resolved at issue and carried alongside.
    always_comb begin
        carry_in = 1'b0;
        sll_idx  = ~st_sh[0] + 1'b1;
        srl_idx  = st_sh[0] - 1'b1;
        if (st_sh[0] != '0) begin
            case (bus.in_op)
                OpSll:        carry_in = bus.in_data[sll_idx];
                OpSrl, OpSra: carry_in = bus.in_data[srl_idx];
                default:      carry_in = 1'b0;
            endcase
        end
    end

    // Carry shift register, stalled with the data pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= '0;
        end else if (advance) begin
            carry_q[0] <= carry_in;
            for (int k = 1; k < PIPE_STAGES; k++) begin
                carry_q[k] <= carry_q[k-1];
            end
        end
    end

    assign bus.out_carry = carry_q[PIPE_STAGES-1];
`endif

    // Upper shamt bits and the last stage's control fields have no consumer.
    logic unused_bits;
    assign unused_bits = ^{bus.in_shamt[WIDTH-1:SHAMT_W], op_q[PIPE_STAGES-1],
                           sh_q[PIPE_STAGES-1], sign_q[PIPE_STAGES-1]};
endmodule

// File: tb/tb_alu_shift_pipe.sv
// Scoreboard bench for alu_shift_pipe (WIDTH=32, PIPE_STAGES=2).
module tb_alu_shift_pipe;
    localparam int WIDTH = 32;
    localparam int PIPE  = 2;

    typedef struct packed {
        logic [31:0] data;
        logic        ill;
        logic        carry;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   lat_chk = 1'b1;
    exp_t sb[$];

    alu_shift_pipe_if #(.WIDTH(WIDTH)) bus ();

    alu_shift_pipe #(.WIDTH(WIDTH), .PIPE_STAGES(PIPE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [31:0] d, input logic [31:0] sh,
                        input logic [31:0] exp_d, input logic exp_ill, input logic exp_c);
        int guard;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_data  = d;
        bus.in_shamt = sh;
        guard = 0;
        #7;
        while (!bus.in_ready) begin
            guard++;
            if (guard > 50) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout: got in_ready=0 for 50 cycles, required 1");
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #8;
        end
        e.data  = exp_d;
        e.ill   = exp_ill;
        e.carry = exp_c;
        e.acc   = cyc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    // Monitor: compare the presented result with the scoreboard head, pop on transfer.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #8;
            if (rst_n && bus.out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got out_data=%0h, required no output",
                             bus.out_data);
                end else begin
                    e = sb[0];
                    check("out_data", bus.out_data, e.data);
                    check("out_illegal", bus.out_illegal, e.ill);
`ifdef ALU_SHIFT_CARRY_EN
                    check("out_carry", bus.out_carry, e.carry);
`endif
                    if (lat_chk && bus.out_ready) check("latency", cyc - e.acc, PIPE);
                    if (bus.out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_illegal", bus.out_illegal, 0);
`ifdef ALU_SHIFT_CARRY_EN
        check("rst_out_carry", bus.out_carry, 0);
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_in_ready", bus.in_ready, 1);

        // Single op, then out_valid must drop.
        send(3'd0, 32'h0000_0001, 32'd31, 32'h8000_0000, 1'b0, 1'b0);
        drain();
        check("valid_drop", bus.out_valid, 0);

        // Back-to-back directed vectors, no stalls.
        send(3'd2, 32'h8000_00F0, 32'd4,    32'hF800_000F, 1'b0, 1'b0);
        send(3'd1, 32'h8000_00F0, 32'd4,    32'h0800_000F, 1'b0, 1'b0);
        send(3'd4, 32'h1234_5678, 32'd8,    32'h7812_3456, 1'b0, 1'b0);
        send(3'd3, 32'h1234_5678, 32'h28,   32'h3456_7812, 1'b0, 1'b0);
        send(3'd1, 32'h0000_0008, 32'd4,    32'h0000_0000, 1'b0, 1'b1);
        send(3'd0, 32'h8000_0001, 32'd1,    32'h0000_0002, 1'b0, 1'b1);
        send(3'd2, 32'h4000_0000, 32'd30,   32'h0000_0001, 1'b0, 1'b0);
        send(3'd2, 32'hFFFF_FFFF, 32'd31,   32'hFFFF_FFFF, 1'b0, 1'b1);
        send(3'd0, 32'hAAAA_AAAA, 32'd32,   32'hAAAA_AAAA, 1'b0, 1'b0);
        send(3'd3, 32'h8000_0000, 32'd1,    32'h0000_0001, 1'b0, 1'b0);
        send(3'd2, 32'h8000_0000, 32'd16,   32'hFFFF_8000, 1'b0, 1'b0);
        send(3'd2, 32'h8000_0001, 32'd7,    32'hFF00_0000, 1'b0, 1'b0);
        drain();

        // Four ops with out_ready held low for three cycles.
        lat_chk = 1'b0;
        fork
            begin
                send(3'd0, 32'h0000_0001, 32'd1, 32'h0000_0002, 1'b0, 1'b0);
                send(3'd0, 32'h0000_0001, 32'd2, 32'h0000_0004, 1'b0, 1'b0);
                send(3'd1, 32'h0000_00F0, 32'd4, 32'h0000_000F, 1'b0, 1'b0);
                send(3'd4, 32'h0000_0001, 32'd1, 32'h8000_0000, 1'b0, 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (3) begin
                    #7;
                    check("stall_in_ready", bus.in_ready, 0);
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();
        lat_chk = 1'b1;

        // Illegal ops pass data through at normal latency.
        send(3'd6, 32'hDEAD_BEEF, 32'd3, 32'hDEAD_BEEF, 1'b1, 1'b0);
        send(3'd5, 32'h0F0F_0F0F, 32'd1, 32'h0F0F_0F0F, 1'b1, 1'b0);
        send(3'd7, 32'h1357_9BDF, 32'd9, 32'h1357_9BDF, 1'b1, 1'b0);
        drain();

        // Reset with two ops in flight: nothing may emerge.
        send(3'd0, 32'h0000_0003, 32'd2, 32'h0000_000C, 1'b0, 1'b0);
        send(3'd1, 32'h0000_0030, 32'd2, 32'h0000_000C, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_out_data", bus.out_data, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) begin
            #7;
            check("post_rst_no_output", bus.out_valid, 0);
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
